// File: rtl/fp12_acc_seq.sv
// fp12_acc_seq: reduces a stream of 12-bit floats to one sum by sequencing
// single adds through an external fixed-latency float adder.
module fp12_acc_seq #(
    parameter int ADD_LATENCY = 5,
    parameter int CNT_W       = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [11:0]      in_data_i,
    input  logic             in_last_i,
    output logic [11:0]      add_a_o,
    output logic [11:0]      add_b_o,
    input  logic [11:0]      add_sum_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [11:0]      out_data_o,
    output logic             out_ovf_o,
    output logic [CNT_W-1:0] out_count_o
);
    localparam int WW = $clog2(ADD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [11:0]       acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic              ovf_q, ovf_d, last_q, last_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              accept;

    assign accept = in_valid_i & in_ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d   = in_data_i;
                ovf_d   = &in_data_i[10:6];
                cnt_d   = CNT_W'(1);
                state_d = in_last_i ? DONE : ACC;
            end
            ACC: if (accept) begin
                a_d     = acc_q;
                b_d     = in_data_i;
                cnt_d   = cnt_q + CNT_W'(1);
                last_d  = in_last_i;
                wait_d  = WW'(ADD_LATENCY);
                state_d = WAIT;
            end
            // the adder output is only trusted on the edge the countdown expires
            WAIT: if (wait_q == '0) begin
                acc_d   = add_sum_i;
                ovf_d   = ovf_q | (&add_sum_i[10:6]);
                state_d = last_q ? DONE : ACC;
            end else begin
                wait_d  = wait_q - WW'(1);
            end
            DONE: state_d = (out_valid_q & out_ready_i) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE) || (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            wait_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            a_q         <= a_d;
            b_q         <= b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = acc_q;
    assign out_ovf_o   = ovf_q;
    assign out_count_o = cnt_q;
    assign add_a_o     = a_q;
    assign add_b_o     = b_q;
endmodule

// File: doc/fp12_acc_seq.md
Name: fp12_acc_seq

Overview:
- Sequencer that reduces a variable-length stream of 12-bit floats (1 sign, 5 exp bias 15, 6 mantissa) to one sum, by driving the existing 5-stage 12-bit float adder and consuming its result.
- Sits between the product/data stream source and the neuron output stage.
- Keeps one add in flight: it issues acc + x, waits out the adder latency, captures the sum, then accepts the next element.

Parameters:
- ADD_LATENCY, 5: edges from the adder sampling its inputs to a valid data_sum_o.
- CNT_W, 10: width of the element counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input element valid.
- in_ready_o  out  1  block accepts an element this cycle.
- in_data_i  in  12  input float element.
- in_last_i  in  1  marks the final element of the vector.
- add_a_o  out  12  adder operand a (registered).
- add_b_o  out  12  adder operand b (registered).
- add_sum_i  in  12  adder result (data_sum_o).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_data_o  out  12  accumulated sum.
- out_ovf_o  out  1  sticky: some partial sum reached exponent 31.
- out_count_o  out  CNT_W  number of elements summed (wraps modulo 2^CNT_W).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_n_i.
- Reset values: state=IDLE; in_ready_o=0, out_valid_o=0, out_ovf_o=0. add_a_o, add_b_o, out_data_o, out_count_o, acc and the wait counter are all 0.
- Ready after reset: in_ready_o is a registered decode of the next state. It rises at the first edge after reset release.
- Handshakes:
  - An element transfers on an edge where in_valid_i & in_ready_o.
  - A result transfers on an edge where out_valid_o & out_ready_i.
- State IDLE (in_ready_o=1): on accept, acc<=in_data_i, ovf<=(in_data_i[10:6]==31), count<=1.
  - in_last_i=1 -> DONE.
  - in_last_i=0 -> ACC.
- State ACC (in_ready_o=1): on accept, add_a_o<=acc, add_b_o<=in_data_i, count<=count+1, last_r<=in_last_i, wait counter<=ADD_LATENCY -> WAIT.
- State WAIT (in_ready_o=0): counter decrements each edge. On the edge where the counter is 0:
  - acc<=add_sum_i and ovf<=ovf | (add_sum_i[10:6]==31).
  - last_r=1 -> DONE; last_r=0 -> ACC.
- WAIT timing: the element accepted at edge E0 is captured at E(ADD_LATENCY+1), i.e. E6 by default. The next accept is no earlier than E7.
- Operand hold: add_a_o/add_b_o hold their values through WAIT. Outside WAIT they are don't-care to the adder.
- State DONE (in_ready_o=0): out_valid_o=1, out_data_o=acc, out_ovf_o=ovf, out_count_o=count, all held stable until the result transfers. On transfer -> IDLE; in_ready_o=1 from the next cycle.
- DONE entry: reached at the accept edge for a single-element vector, or at the capture edge otherwise.
- out_valid_o never depends combinationally on out_ready_i. All outputs are registered.
- Backpressure: in_valid_i low in IDLE/ACC leaves the state unchanged. in_data_i is ignored while in_ready_o=0.
- Zero-length vectors cannot occur; the first element always loads acc directly, with no add.
- Reset mid-operation (any state): return to reset values immediately. The in-flight adder result is discarded, since the adder pipeline self-flushes within ADD_LATENCY cycles and is never sampled outside WAIT.
- Overflow: no saturation logic here. The adder already saturates to exponent 31; this block only flags it.

Test Plan:
- Single element: in_data_i=0x3C0 (1.0) with in_last_i=1, accepted at E0 -> out_valid_o high after E0, out_data_o=0x3C0, out_count_o=1, out_ovf_o=0. Hold out_ready_i=0 for 3 cycles -> outputs stable, in_ready_o=0.
- Four x 0x3C0 with in_valid_i held high, last on the 4th:
  - Accepts at E0, E1, E8, E15.
  - Captures at E7, E14, E21.
  - out_data_o=0x440 (4.0), out_count_o=4, out_valid_o high after E21.
- Cancellation: 0x3C0 then 0xBC0 (-1.0, last) -> out_data_o=0x000, out_ovf_o=0.
- Mixed: 0x3E0 (1.5) then 0x420 (3.0, last) -> add_a_o=0x3E0 and add_b_o=0x420 during WAIT; out_data_o=0x448 (4.5).
- Overflow: 0x7C0 then 0x7C0 (last) -> adder returns 0x7FF; out_data_o=0x7FF, out_ovf_o=1. The next vector 0x3C0 (last) -> out_ovf_o=0.
- Reset in WAIT: assert rst_n_i at E3 of an add.
  - All outputs drop to 0 immediately.
  - After release, in_ready_o=1 at the next edge.
  - A new vector 0x400 (2.0, last) returns 0x400, count=1.
